alu_rr_scheduler: RTL and testbench

- Shares one combinational ALU (opcode-selected, IN_W-bit operands, OUT_W-bit result) between NREQ requesters.
- Arbitrates round-robin, latches the winner's operands and opcode, and drives the ALU from registers.
- Captures the result and returns it, tagged with the requester ID, over a valid/ready response channel.
- Sits between requester logic (register file / control units) and the shared ALU instance.

---
 rtl/alu_rr_scheduler.sv | 175 +++++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin front end for one shared combinational ALU.
// Grants one requester at a time and registers its opcode and operands onto
// the ALU. The result is captured one cycle later and returned on a
// valid/ready response channel, tagged with the requester index. Opcodes at or
// above NUM_OPS skip the ALU and come back at once with rsp_err set.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_ready   per-requester request handshake (ready one-hot or 0)
//   req_op/req_a/req_b    packed per-requester opcode and operands
//   alu_op/alu_in1/alu_in2  registered ALU drive
//   alu_out               combinational ALU result
//   rsp_valid/rsp_ready   response handshake
//   rsp_id/rsp_data/rsp_err  response payload
module alu_rr_scheduler #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned OPW     = 3,
  parameter int unsigned NUM_OPS = 6,
  parameter int unsigned IN_W    = 5,
  parameter int unsigned OUT_W   = 32,
  parameter int unsigned IDW     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OPW-1:0]  req_op,
  input  logic [NREQ*IN_W-1:0] req_a,
  input  logic [NREQ*IN_W-1:0] req_b,
  output logic [OPW-1:0]       alu_op,
  output logic [IN_W-1:0]      alu_in1,
  output logic [IN_W-1:0]      alu_in2,
  input  logic [OUT_W-1:0]     alu_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [OUT_W-1:0]     rsp_data,
  output logic                 rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [OPW-1:0]       alu_op_q, alu_op_d;
  logic [IN_W-1:0]      alu_in1_q, alu_in1_d;
  logic [IN_W-1:0]      alu_in2_q, alu_in2_d;
  logic [IDW-1:0]       rsp_id_q, rsp_id_d;
  logic [OUT_W-1:0]     rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 rsp_valid_q, rsp_valid_d;

  logic                 grant_found;
  int unsigned          grant_sel;
  int unsigned          scan_idx;
  logic [NREQ-1:0]      valid_sh;
  logic [NREQ*OPW-1:0]  op_sh;
  logic [NREQ*IN_W-1:0] a_sh;
  logic [NREQ*IN_W-1:0] b_sh;
  logic [OPW-1:0]       win_op;
  logic [IN_W-1:0]      win_a;
  logic [IN_W-1:0]      win_b;

  // Round-robin search: first valid requester strictly after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_sel   = 0;
    scan_idx    = 0;
    valid_sh    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      scan_idx = (32'(rr_ptr_q) + k) % NREQ;
      valid_sh = req_valid >> scan_idx;
      if (!grant_found && valid_sh[0]) begin
        grant_found = 1'b1;
        grant_sel   = scan_idx;
      end
    end
  end

  // Winner's payload, extracted with shifts so the select width is parameter-free.
  always_comb begin
    op_sh  = req_op >> (grant_sel * OPW);
    a_sh   = req_a  >> (grant_sel * IN_W);
    b_sh   = req_b  >> (grant_sel * IN_W);
    win_op = op_sh[OPW-1:0];
    win_a  = a_sh[IN_W-1:0];
    win_b  = b_sh[IN_W-1:0];
  end

  // Next-state and datapath load logic.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    alu_op_d   = alu_op_q;
    alu_in1_d  = alu_in1_q;
    alu_in2_d  = alu_in2_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    req_ready  = '0;

    unique case (state_q)
      S_IDLE: begin
        // No grant is offered while reset is held so req_ready reads 0.
        if (grant_found && !rst) begin
          req_ready = NREQ'(1) << grant_sel;
          alu_op_d  = win_op;
          alu_in1_d = win_a;
          alu_in2_d = win_b;
          rsp_id_d  = IDW'(grant_sel);
          if (32'(win_op) < NUM_OPS) begin
            state_d = S_EXEC;
          end else begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            state_d    = S_RESP;
          end
        end
      end
      S_EXEC: begin
        rsp_data_d = alu_out;
        rsp_err_d  = 1'b0;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rr_ptr_d = rsp_id_q;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rsp_valid_d = (state_d == S_RESP);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= IDW'(NREQ - 1);
      alu_op_q    <= '0;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      alu_op_q    <= alu_op_d;
      alu_in1_q   <= alu_in1_d;
      alu_in2_q   <= alu_in2_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_in1   = alu_in1_q;
  assign alu_in2   = alu_in2_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a small reference ALU attached.
module tb_alu_rr_scheduler;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned OPW     = 3;
  localparam int unsigned NUM_OPS = 6;
  localparam int unsigned IN_W    = 5;
  localparam int unsigned OUT_W   = 32;
  localparam int unsigned IDW     = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*OPW-1:0]  req_op;
  logic [NREQ*IN_W-1:0] req_a;
  logic [NREQ*IN_W-1:0] req_b;
  logic [OPW-1:0]       alu_op;
  logic [IN_W-1:0]      alu_in1;
  logic [IN_W-1:0]      alu_in2;
  logic [OUT_W-1:0]     alu_out;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [OUT_W-1:0]     rsp_data;
  logic                 rsp_err;

  int n_checks = 0;
  int n_pass   = 0;

  alu_rr_scheduler #(
    .NREQ(NREQ), .OPW(OPW), .NUM_OPS(NUM_OPS),
    .IN_W(IN_W), .OUT_W(OUT_W), .IDW(IDW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Reference ALU; illegal codes return a marker that must never reach rsp_data.
  always_comb begin
    case (alu_op)
      3'd0:    alu_out = 32'(alu_in1) + 32'(alu_in2);
      3'd1:    alu_out = 32'(alu_in1) - 32'(alu_in2);
      3'd2:    alu_out = 32'(alu_in1 & alu_in2);
      3'd3:    alu_out = 32'(alu_in1 | alu_in2);
      3'd4:    alu_out = 32'(alu_in1 ^ alu_in2);
      3'd5:    alu_out = 32'(alu_in1) * 32'(alu_in2);
      default: alu_out = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [OPW-1:0] op,
                         input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
    req_op[i*OPW +: OPW]  = op;
    req_a[i*IN_W +: IN_W] = a;
    req_b[i*IN_W +: IN_W] = b;
  endtask

  logic [OUT_W-1:0] rot_data [4];
  logic [IDW-1:0]   rot_id;

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    rot_data[0] = 32'h16;
    rot_data[1] = 32'h02;
    rot_data[2] = 32'h08;
    rot_data[3] = 32'h0E;

    // Reset values
    #1;
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_alu_op",    64'(alu_op),    64'h0);
    check("rst_alu_in1",   64'(alu_in1),   64'h0);
    check("rst_rsp_data",  64'(rsp_data),  64'h0);
    check("rst_rsp_err",   64'(rsp_err),   64'h0);
    next_cycle();
    rst = 1'b0;

    // Single legal op from requester 0: 0x0A + 0x05
    set_req(0, 3'd0, 5'h0A, 5'h05);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    check("t1_grant", 64'(req_ready), 64'b0001);
    next_cycle();
    req_valid = '0;
    check("t1_exec_ready", 64'(req_ready), 64'h0);
    check("t1_exec_valid", 64'(rsp_valid), 64'h0);
    check("t1_alu_in1",    64'(alu_in1),   64'h0A);
    check("t1_alu_in2",    64'(alu_in2),   64'h05);
    next_cycle();
    check("t1_rsp_valid", 64'(rsp_valid), 64'h1);
    check("t1_rsp_id",    64'(rsp_id),    64'h0);
    check("t1_rsp_data",  64'(rsp_data),  64'h0F);
    check("t1_rsp_err",   64'(rsp_err),   64'h0);
    next_cycle();
    check("t1_idle_valid", 64'(rsp_valid), 64'h0);

    // All four valid from a fresh reset: grants 0,1,2,3,0,1 every 3 cycles
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 3'(i), 5'h0C, 5'h0A);
    req_valid = 4'b1111;
    #1;
    for (int g = 0; g < 6; g++) begin
      rot_id = IDW'(g % 4);
      check("t2_grant", 64'(req_ready), 64'(4'b0001 << rot_id));
      next_cycle();
      check("t2_exec_ready", 64'(req_ready), 64'h0);
      next_cycle();
      check("t2_rsp_valid", 64'(rsp_valid), 64'h1);
      check("t2_rsp_id",    64'(rsp_id),    64'(rot_id));
      check("t2_rsp_data",  64'(rsp_data),  64'(rot_data[rot_id]));
      next_cycle();
    end
    req_valid = '0;
    #1;
    check("t2_idle_ready", 64'(req_ready), 64'h0);

    // Stall: requester 1 (5*3*7 -> 3*7=0x15) held in RESP, requester 3 waits
    set_req(1, 3'd5, 5'h03, 5'h07);
    set_req(3, 3'd2, 5'h1F, 5'h11);
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    check("t4_grant1", 64'(req_ready), 64'b0010);
    next_cycle();
    req_valid = 4'b1010;
    next_cycle();
    for (int c = 0; c < 10; c++) begin
      check("t4_stall_valid", 64'(rsp_valid), 64'h1);
      check("t4_stall_id",    64'(rsp_id),    64'h1);
      check("t4_stall_data",  64'(rsp_data),  64'h15);
      check("t4_stall_ready", 64'(req_ready), 64'h0);
      if (c != 9) next_cycle();
    end
    rsp_ready = 1'b1;
    next_cycle();
    check("t4_grant3", 64'(req_ready), 64'b1000);
    next_cycle();
    req_valid = '0;
    next_cycle();
    check("t4_rsp_id",   64'(rsp_id),   64'h3);
    check("t4_rsp_data", 64'(rsp_data), 64'h11);
    next_cycle();

    // Illegal opcode from requester 2: response one cycle after grant
    set_req(2, 3'd7, 5'h04, 5'h04);
    req_valid = 4'b0100;
    #1;
    check("t3_grant", 64'(req_ready), 64'b0100);
    next_cycle();
    req_valid = '0;
    check("t3_rsp_valid", 64'(rsp_valid), 64'h1);
    check("t3_rsp_id",    64'(rsp_id),    64'h2);
    check("t3_rsp_err",   64'(rsp_err),   64'h1);
    check("t3_rsp_data",  64'(rsp_data),  64'h0);
    check("t3_alu_op",    64'(alu_op),    64'h7);
    next_cycle();
    check("t3_idle_valid", 64'(rsp_valid), 64'h0);

    // Reset during EXEC abandons the op
    set_req(0, 3'd0, 5'h01, 5'h02);
    req_valid = 4'b0001;
    #1;
    check("t5_grant", 64'(req_ready), 64'b0001);
    next_cycle();
    req_valid = '0;
    check("t5_exec_valid", 64'(rsp_valid), 64'h0);
    rst = 1'b1;
    #1;
    check("t5_rst_valid",  64'(rsp_valid), 64'h0);
    check("t5_rst_alu_in", 64'(alu_in1),   64'h0);
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("t5_no_rsp", 64'(rsp_valid), 64'h0);
      next_cycle();
    end

    // Simultaneous 0/1 after reset: 0 wins, 1 drops out in the grant cycle
    set_req(0, 3'd0, 5'h1F, 5'h1F);
    set_req(1, 3'd4, 5'h01, 5'h02);
    req_valid = 4'b0011;
    #1;
    check("t6_grant0", 64'(req_ready), 64'b0001);
    req_valid = 4'b0001;
    next_cycle();
    req_valid = '0;
    check("t6_exec_ready", 64'(req_ready), 64'h0);
    next_cycle();
    check("t6_rsp_valid", 64'(rsp_valid), 64'h1);
    check("t6_rsp_id",    64'(rsp_id),    64'h0);
    check("t6_rsp_data",  64'(rsp_data),  64'h3E);
    check("t6_rsp_err",   64'(rsp_err),   64'h0);
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      check("t6_no_req1_valid", 64'(rsp_valid), 64'h0);
      check("t6_no_req1_ready", 64'(req_ready), 64'h0);
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
